// File: rtl/diff_pkg.sv
// Shared types and constants for the paired-sample transmit path.
// DIFF_OFFSET is the constant the downstream differencer adds to (second - first).
package diff_pkg;
   localparam int W_DEF = 20;
   localparam logic [19:0] DIFF_OFFSET = 20'h007F0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND2 = 2'd1,
      HOLD  = 2'd2
   } tx_state_e;
endpackage

// File: rtl/pair_fifo.sv
// Synchronous FIFO holding packed {first, second} pairs; head is visible
// combinationally so the FSM can pop and use it in the same cycle.
module pair_fifo #(
   parameter int DW    = 40,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [DW-1:0]            wr_data,
   input  logic                     rd_en,
   output logic [DW-1:0]            rd_data,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign rd_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/diff_pair_tx.sv
// Serialises buffered (first, second) timestamp pairs onto the dval/mlt bus
// as two back-to-back strobes followed by a GAP-cycle idle hold.
module diff_pair_tx
   import diff_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int DEPTH = 4,
   parameter int GAP   = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_first,
   input  logic [W-1:0] s_second,
   output logic         dval,
   output logic [W-1:0] mlt,
   output logic         busy,
   output logic [7:0]   pair_cnt
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]    GAP_LD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   tx_state_e      state, state_n;
   logic [W-1:0]   sec_q, sec_n, mlt_n;
   logic [3:0]     gap_cnt, gap_n;
   logic [7:0]     cnt_n;
   logic           dval_n, push, pop;
   logic [2*W-1:0] head;
   logic [CW-1:0]  count;

   // Full FIFO refuses a push even when a pop happens in the same cycle.
   assign s_ready = (count < DEPTH_C);
   assign push    = s_valid & s_ready;
   assign busy    = (count != '0) || (state != IDLE);

   pair_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data ({s_first, s_second}),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count)
   );

   always_comb begin
      state_n = state;
      dval_n  = 1'b0;
      mlt_n   = '0;
      sec_n   = sec_q;
      gap_n   = gap_cnt;
      cnt_n   = pair_cnt;
      pop     = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               dval_n  = 1'b1;
               mlt_n   = head[2*W-1:W];
               sec_n   = head[W-1:0];
               state_n = SEND2;
            end
         end
         SEND2: begin
            dval_n = 1'b1;
            mlt_n  = sec_q;
            cnt_n  = pair_cnt + 8'd1;
            if (GAP > 0) begin
               state_n = HOLD;
               gap_n   = GAP_LD;
            end else begin
               state_n = IDLE;
            end
         end
         HOLD: begin
            if (gap_cnt == 4'd0) state_n = IDLE;
            else                 gap_n   = gap_cnt - 4'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         dval     <= 1'b0;
         mlt      <= '0;
         sec_q    <= '0;
         gap_cnt  <= 4'd0;
         pair_cnt <= 8'd0;
      end else begin
         state    <= state_n;
         dval     <= dval_n;
         mlt      <= mlt_n;
         sec_q    <= sec_n;
         gap_cnt  <= gap_n;
         pair_cnt <= cnt_n;
      end
   end
endmodule
